// File: rtl/tune_sequencer_pkg.sv
// ============================================================================
//  Module      : tune_sequencer_pkg
//  Description : Shared FSM state encoding and default timing constants for
//                the PLL tune sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package tune_sequencer_pkg;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_WRITE     = 3'd1,
        S_WAIT_WR   = 3'd2,
        S_RECONF    = 3'd3,
        S_WAIT_RC   = 3'd4,
        S_PRST      = 3'd5,
        S_WAIT_LOCK = 3'd6
    } state_t;

    localparam int DEF_RST_CYCLES   = 4;
    localparam int DEF_LOCK_TIMEOUT = 4096;
    localparam int DEF_MAX_RETRY    = 3;

endpackage

`default_nettype wire

// File: rtl/tune_req_slot.sv
// ============================================================================
//  Module      : tune_req_slot
//  Description : Single-entry pending request holder; newest request wins.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tune_req_slot #(
    parameter int W = 9
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_req,
    input  logic [W-1:0] i_freq,
    input  logic         i_grant,
    output logic         o_pending,
    output logic [W-1:0] o_value
);

    logic         r_pending;
    logic [W-1:0] r_value;

    // A request landing on the grant edge re-arms the slot so it is not lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pending <= 1'b0;
            r_value   <= '0;
        end else if (i_req) begin
            r_pending <= 1'b1;
            r_value   <= i_freq;
        end else if (i_grant) begin
            r_pending <= 1'b0;
        end
    end

    assign o_pending = r_pending;
    assign o_value   = r_value;

endmodule

`default_nettype wire

// File: rtl/tune_sequencer.sv
// ============================================================================
//  Module      : tune_sequencer
//  Description : Arbitrates host/front-panel tune requests and drives the PLL
//                reconfiguration, reset and lock-retry sequence.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tune_sequencer
    import tune_sequencer_pkg::*;
#(
    parameter int FREQ_W       = 9,
    parameter int RST_CYCLES   = DEF_RST_CYCLES,
    parameter int LOCK_TIMEOUT = DEF_LOCK_TIMEOUT,
    parameter int MAX_RETRY    = DEF_MAX_RETRY
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              host_req,
    input  logic [FREQ_W-1:0] host_freq,
    input  logic              knob_req,
    input  logic [FREQ_W-1:0] knob_freq,
    output logic              host_ack,
    output logic              knob_ack,
    output logic [FREQ_W-1:0] cfg_data,
    output logic              cfg_write,
    output logic              cfg_reconfig,
    input  logic              cfg_busy,
    output logic              pll_rst,
    input  logic              pll_locked,
    output logic [FREQ_W-1:0] cur_freq,
    output logic              locked,
    output logic              fault
);

    localparam int RC_W = $clog2(RST_CYCLES) + 1;
    localparam int TO_W = $clog2(LOCK_TIMEOUT) + 1;
    localparam int RT_W = $clog2(MAX_RETRY + 1) + 1;
    localparam logic [RC_W-1:0] c_rst_last  = RC_W'(RST_CYCLES - 1);
    localparam logic [TO_W-1:0] c_to_last   = TO_W'(LOCK_TIMEOUT - 1);
    localparam logic [RT_W-1:0] c_max_retry = RT_W'(MAX_RETRY);

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_first;
    logic [RC_W-1:0]   r_rcnt;
    logic [TO_W-1:0]   r_tcnt;
    logic [RT_W-1:0]   r_retry;
    logic [FREQ_W-1:0] r_cfg_data;
    logic [FREQ_W-1:0] r_cur_freq;
    logic              r_locked;
    logic              r_fault;
    logic              r_pll_rst;
    logic              r_host_ack;
    logic              r_knob_ack;

    logic              w_host_pend;
    logic              w_knob_pend;
    logic [FREQ_W-1:0] w_host_val;
    logic [FREQ_W-1:0] w_knob_val;
    logic              w_grant_host;
    logic              w_grant_knob;
    logic              w_lock_ok;
    logic              w_retry;
    logic              w_give_up;

    tune_req_slot #(.W(FREQ_W)) u_host_slot (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_req     (host_req),
        .i_freq    (host_freq),
        .i_grant   (w_grant_host),
        .o_pending (w_host_pend),
        .o_value   (w_host_val)
    );

    tune_req_slot #(.W(FREQ_W)) u_knob_slot (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_req     (knob_req),
        .i_freq    (knob_freq),
        .i_grant   (w_grant_knob),
        .o_pending (w_knob_pend),
        .o_value   (w_knob_val)
    );

    always_comb begin
        w_state_nxt  = r_state;
        w_grant_host = 1'b0;
        w_grant_knob = 1'b0;
        w_lock_ok    = 1'b0;
        w_retry      = 1'b0;
        w_give_up    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_host_pend) begin
                    w_grant_host = 1'b1;
                    w_state_nxt  = S_WRITE;
                end else if (w_knob_pend) begin
                    w_grant_knob = 1'b1;
                    w_state_nxt  = S_WRITE;
                end
            end
            S_WRITE:   w_state_nxt = S_WAIT_WR;
            S_WAIT_WR: if (!r_first && !cfg_busy) w_state_nxt = S_RECONF;
            S_RECONF:  w_state_nxt = S_WAIT_RC;
            S_WAIT_RC: if (!r_first && !cfg_busy) w_state_nxt = S_PRST;
            S_PRST:    if (r_rcnt == c_rst_last) w_state_nxt = S_WAIT_LOCK;
            S_WAIT_LOCK: begin
                if (pll_locked) begin
                    w_lock_ok   = 1'b1;
                    w_state_nxt = S_IDLE;
                end else if (r_tcnt == c_to_last) begin
                    // Retry while the count after increment stays within MAX_RETRY.
                    if (r_retry < c_max_retry) begin
                        w_retry     = 1'b1;
                        w_state_nxt = S_WRITE;
                    end else begin
                        w_give_up   = 1'b1;
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default:   w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_first    <= 1'b0;
            r_rcnt     <= '0;
            r_tcnt     <= '0;
            r_retry    <= '0;
            r_cfg_data <= '0;
            r_cur_freq <= '0;
            r_locked   <= 1'b0;
            r_fault    <= 1'b0;
            r_pll_rst  <= 1'b1;
            r_host_ack <= 1'b0;
            r_knob_ack <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_first    <= (r_state == S_WRITE) || (r_state == S_RECONF);
            r_pll_rst  <= (w_state_nxt == S_PRST);
            r_host_ack <= w_grant_host;
            r_knob_ack <= w_grant_knob;
            r_rcnt     <= (r_state == S_PRST && w_state_nxt == S_PRST) ? r_rcnt + 1'b1 : '0;
            r_tcnt     <= (r_state == S_WAIT_LOCK && w_state_nxt == S_WAIT_LOCK) ? r_tcnt + 1'b1 : '0;

            if (w_grant_host)      r_cfg_data <= w_host_val;
            else if (w_grant_knob) r_cfg_data <= w_knob_val;

            if (w_retry)                                          r_retry <= r_retry + 1'b1;
            else if (w_grant_host || w_grant_knob || w_lock_ok || w_give_up) r_retry <= '0;

            if (w_lock_ok)                                 r_locked <= 1'b1;
            else if (w_state_nxt == S_WRITE)               r_locked <= 1'b0;
            else if (r_state == S_IDLE && !pll_locked)     r_locked <= 1'b0;

            if (w_lock_ok)      r_fault <= 1'b0;
            else if (w_give_up) r_fault <= 1'b1;

            if (w_lock_ok) r_cur_freq <= r_cfg_data;
        end
    end

    assign cfg_write    = (r_state == S_WRITE);
    assign cfg_reconfig = (r_state == S_RECONF);
    assign cfg_data     = r_cfg_data;
    assign pll_rst      = r_pll_rst;
    assign host_ack     = r_host_ack;
    assign knob_ack     = r_knob_ack;
    assign cur_freq     = r_cur_freq;
    assign locked       = r_locked;
    assign fault        = r_fault;

endmodule

`default_nettype wire

// File: tb/tb_tune_sequencer.sv
// ============================================================================
//  Module      : tb_tune_sequencer
//  Description : Scoreboard bench for tune_sequencer with engine/PLL models.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tune_sequencer;

    localparam int FREQ_W       = 9;
    localparam int RST_CYCLES   = 4;
    localparam int LOCK_TIMEOUT = 256;
    localparam int MAX_RETRY    = 3;
    localparam int LOCK_DLY     = 10;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              host_req = 1'b0;
    logic [FREQ_W-1:0] host_freq = '0;
    logic              knob_req = 1'b0;
    logic [FREQ_W-1:0] knob_freq = '0;
    logic              host_ack, knob_ack;
    logic [FREQ_W-1:0] cfg_data;
    logic              cfg_write, cfg_reconfig;
    logic              cfg_busy = 1'b0;
    logic              pll_rst;
    logic              pll_locked = 1'b0;
    logic [FREQ_W-1:0] cur_freq;
    logic              locked, fault;

    always #5 clk = ~clk;

    tune_sequencer #(
        .FREQ_W(FREQ_W), .RST_CYCLES(RST_CYCLES),
        .LOCK_TIMEOUT(LOCK_TIMEOUT), .MAX_RETRY(MAX_RETRY)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .host_req(host_req), .host_freq(host_freq),
        .knob_req(knob_req), .knob_freq(knob_freq),
        .host_ack(host_ack), .knob_ack(knob_ack),
        .cfg_data(cfg_data), .cfg_write(cfg_write), .cfg_reconfig(cfg_reconfig),
        .cfg_busy(cfg_busy), .pll_rst(pll_rst), .pll_locked(pll_locked),
        .cur_freq(cur_freq), .locked(locked), .fault(fault)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Environment models: engine stays busy busy_len cycles per strobe; PLL locks LOCK_DLY cycles after reset release.
    int   busy_len = 3;
    int   busy_cnt = 0;
    logic lock_en  = 1'b1;
    int   lcnt     = 0;

    always @(negedge clk) begin
        if (cfg_write || cfg_reconfig) begin
            busy_cnt = busy_len;
        end else if (busy_cnt > 0) begin
            busy_cnt--;
        end
        cfg_busy = (busy_cnt > 0);

        if (pll_rst) begin
            pll_locked = 1'b0;
            lcnt       = 0;
        end else if (lock_en && !pll_locked) begin
            lcnt++;
            if (lcnt >= LOCK_DLY) pll_locked = 1'b1;
        end
    end

    // Reference model: one latest-value slot per requester, host wins ties.
    typedef struct packed {
        logic              f;
        logic [FREQ_W-1:0] v;
    } res_t;

    logic              mh_pend = 1'b0, mk_pend = 1'b0;
    logic [FREQ_W-1:0] mh_val = '0, mk_val = '0;
    logic              ph_pend = 1'b0, pk_pend = 1'b0;
    logic [FREQ_W-1:0] ph_val = '0, pk_val = '0;
    logic              h_edge = 1'b0, k_edge = 1'b0;

    logic [FREQ_W-1:0] write_q[$];
    logic [FREQ_W-1:0] reconf_q[$];
    res_t              res_q[$];

    always @(posedge clk) begin
        if (rst_n) begin
            ph_pend = mh_pend; ph_val = mh_val;
            pk_pend = mk_pend; pk_val = mk_val;
            h_edge  = host_req;
            k_edge  = knob_req;
            if (host_req) begin mh_pend = 1'b1; mh_val = host_freq; end
            if (knob_req) begin mk_pend = 1'b1; mk_val = knob_freq; end
        end
    end

    task automatic expect_seq(input logic [FREQ_W-1:0] v);
        int nseq;
        res_t r;
        nseq = lock_en ? 1 : 1 + MAX_RETRY;
        for (int i = 0; i < nseq; i++) begin
            write_q.push_back(v);
            reconf_q.push_back(v);
        end
        r.f = !lock_en;
        r.v = v;
        res_q.push_back(r);
    endtask

    logic prev_locked = 1'b0, prev_fault = 1'b0;
    logic rst_armed = 1'b0;
    int   rst_len = 0;
    res_t mon_r;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_locked = 1'b0;
            prev_fault  = 1'b0;
            rst_armed   = 1'b0;
        end else begin
            if (host_ack) begin
                chk("host_grant_pending", {31'b0, ph_pend}, 32'd1);
                if (!h_edge) mh_pend = 1'b0;
                expect_seq(ph_val);
            end
            if (knob_ack) begin
                chk("panel_grant_order", {30'b0, pk_pend, ph_pend}, 32'd2);
                if (!k_edge) mk_pend = 1'b0;
                expect_seq(pk_val);
            end
            if (cfg_write) begin
                if (write_q.size() == 0) chk("unexpected_cfg_write", 32'd1, 32'd0);
                else chk("cfg_data_write", {23'b0, cfg_data}, {23'b0, write_q.pop_front()});
                chk("locked_low_in_write", {31'b0, locked}, 32'd0);
            end
            if (cfg_reconfig) begin
                if (reconf_q.size() == 0) chk("unexpected_cfg_reconfig", 32'd1, 32'd0);
                else chk("cfg_data_reconf", {23'b0, cfg_data}, {23'b0, reconf_q.pop_front()});
            end
            if (rst_armed) begin
                if (pll_rst) rst_len++;
                else if (rst_len > 0) begin
                    chk("pll_rst_len", rst_len, RST_CYCLES);
                    rst_armed = 1'b0;
                end
            end
            if (cfg_reconfig) begin
                rst_armed = 1'b1;
                rst_len   = 0;
            end
            if (locked && !prev_locked) begin
                if (res_q.size() == 0) chk("unexpected_lock", 32'd1, 32'd0);
                else begin
                    mon_r = res_q.pop_front();
                    chk("lock_not_fault", {31'b0, mon_r.f}, 32'd0);
                    chk("cur_freq_on_lock", {23'b0, cur_freq}, {23'b0, mon_r.v});
                    chk("fault_clear_on_lock", {31'b0, fault}, 32'd0);
                end
            end
            if (fault && !prev_fault) begin
                if (res_q.size() == 0) chk("unexpected_fault", 32'd1, 32'd0);
                else begin
                    mon_r = res_q.pop_front();
                    chk("fault_expected", {31'b0, mon_r.f}, 32'd1);
                    chk("locked_low_on_fault", {31'b0, locked}, 32'd0);
                end
            end
            prev_locked = locked;
            prev_fault  = fault;
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic h, input logic [FREQ_W-1:0] hv,
                         input logic k, input logic [FREQ_W-1:0] kv);
        host_req = h; host_freq = hv;
        knob_req = k; knob_freq = kv;
        tick();
        host_req = 1'b0;
        knob_req = 1'b0;
    endtask

    task automatic wait_quiet(input int budget, input string nm);
        int c = 0;
        tick(2);
        while ((write_q.size() != 0 || reconf_q.size() != 0 || res_q.size() != 0 ||
                mh_pend || mk_pend) && c < budget) begin
            tick();
            c++;
        end
        tick(2);
        chk(nm, {31'b0, c >= budget}, 32'd0);
    endtask

    task automatic flush_model();
        write_q.delete();
        reconf_q.delete();
        res_q.delete();
        mh_pend = 1'b0;
        mk_pend = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string pfx);
        chk({pfx, "_pll_rst"},  {31'b0, pll_rst}, 32'd1);
        chk({pfx, "_cfg_write"}, {31'b0, cfg_write}, 32'd0);
        chk({pfx, "_cfg_reconfig"}, {31'b0, cfg_reconfig}, 32'd0);
        chk({pfx, "_acks"}, {30'b0, host_ack, knob_ack}, 32'd0);
        chk({pfx, "_cfg_data"}, {23'b0, cfg_data}, 32'd0);
        chk({pfx, "_cur_freq"}, {23'b0, cur_freq}, 32'd0);
        chk({pfx, "_locked_fault"}, {30'b0, locked, fault}, 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int c;
        tick(3);
        chk_reset_outputs("reset");
        rst_n = 1'b1;
        tick();
        chk("pll_rst_release", {31'b0, pll_rst}, 32'd0);

        // Single host tune with a busy engine.
        busy_len = 3;
        issue(1'b1, 9'h07, 1'b0, '0);
        wait_quiet(2000, "host_tune_done");
        chk("cur_freq_0x07", {23'b0, cur_freq}, 32'h07);
        chk("locked_0x07", {31'b0, locked}, 32'd1);

        // Simultaneous requests: host first, then front panel.
        issue(1'b1, 9'h10, 1'b1, 9'h20);
        wait_quiet(4000, "both_tune_done");
        chk("cur_freq_0x20", {23'b0, cur_freq}, 32'h20);

        // Front-panel requests collapse while a sequence is running.
        issue(1'b1, 9'h40, 1'b0, '0);
        tick(3);
        issue(1'b0, '0, 1'b1, 9'h01);
        tick(2);
        issue(1'b0, '0, 1'b1, 9'h02);
        issue(1'b0, '0, 1'b1, 9'h03);
        wait_quiet(4000, "collapse_done");
        chk("cur_freq_0x03", {23'b0, cur_freq}, 32'h03);

        // Lock never arrives: four sequences then fault; a later lock clears it.
        lock_en = 1'b0;
        issue(1'b1, 9'h55, 1'b0, '0);
        wait_quiet(5 * (LOCK_TIMEOUT + 60), "fault_seq_done");
        chk("fault_set", {31'b0, fault}, 32'd1);
        chk("locked_after_fault", {31'b0, locked}, 32'd0);
        lock_en = 1'b1;
        tick(20);
        chk("fault_sticky", {31'b0, fault}, 32'd1);
        issue(1'b0, '0, 1'b1, 9'h66);
        wait_quiet(2000, "recover_done");
        chk("fault_cleared", {31'b0, fault}, 32'd0);
        chk("cur_freq_0x66", {23'b0, cur_freq}, 32'h66);

        // Asynchronous reset in the middle of WAIT_RC.
        issue(1'b1, 9'h11, 1'b0, '0);
        c = 0;
        while (!cfg_reconfig && c < 200) begin tick(); c++; end
        chk("reach_reconfig", {31'b0, c >= 200}, 32'd0);
        tick(2);
        #2 rst_n = 1'b0;
        flush_model();
        #1;
        chk_reset_outputs("midseq_reset");
        tick(2);
        rst_n = 1'b1;
        tick(60);
        chk("no_resume_locked", {31'b0, locked}, 32'd0);

        // Randomized traffic with random engine busy time.
        for (int i = 0; i < 40; i++) begin
            logic [1:0] sel;
            sel = 2'($urandom_range(0, 3));
            busy_len = $urandom_range(0, 3);
            issue(sel[0], FREQ_W'($urandom), sel[1], FREQ_W'($urandom));
            tick($urandom_range(1, 12));
        end
        wait_quiet(20000, "random_done");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
